// File: rtl/egg_box_controller_pkg.sv
// Shared state encoding and defaults for the dozen-packing station controller.
package egg_box_controller_pkg;

  typedef enum logic [2:0] {
    StWaitBox    = 3'd0,
    StFill       = 3'd1,
    StEject      = 3'd2,
    StWaitAckLow = 3'd3,
    StFault      = 3'd4
  } state_e;

  localparam int unsigned ItemsPerBoxDefault = 12;

endpackage

// File: rtl/egg_box_controller_mod_n_counter.sv
// Item counter: counts 0..N with sync clear; last_o flags that the next increment fills the box.
module egg_box_controller_mod_n_counter #(
  parameter int unsigned N = 12,
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o,
  output logic         last_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == W'(N)) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == W'(N - 1));

endmodule

// File: rtl/egg_box_controller.sv
// Dozen-packing station sequencer: conveyor control, item counting, eject handshake with
// timeout, and finished-box tally. All outputs are registered.
module egg_box_controller
  import egg_box_controller_pkg::*;
#(
  parameter int unsigned ITEMS_PER_BOX = ItemsPerBoxDefault,
  parameter int unsigned CNT_W         = 4,
  parameter int unsigned BOX_W         = 8,
  parameter int unsigned EJECT_TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             item_sensor,
  input  logic             box_present,
  input  logic             eject_ack,
  input  logic             fault_clr,
  output logic             conveyor_en,
  output logic             eject_req,
  output logic [CNT_W-1:0] item_count,
  output logic [BOX_W-1:0] box_count,
  output logic             lost_item,
  output logic             fault
);

  localparam int unsigned TimerW = $clog2(EJECT_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic               item_q;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [BOX_W-1:0]   box_q, box_d;
  logic               conv_q, req_q, lost_q, fault_q;
  logic               item_evt, cnt_en, cnt_clr, cnt_last;

  assign item_evt = item_sensor & ~item_q;

  always_comb begin
    state_d = state_q;
    box_d   = box_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      StWaitBox: begin
        if (box_present) state_d = StFill;
      end
      StFill: begin
        // A filling item wins over box removal in the same cycle.
        if (item_evt) begin
          cnt_en = 1'b1;
          if (cnt_last) begin
            state_d = StEject;
          end else if (!box_present) begin
            state_d = StWaitBox;
          end
        end else if (!box_present) begin
          state_d = StWaitBox;
        end
      end
      StEject: begin
        // Ack takes priority over a timeout in the same cycle.
        if (eject_ack) begin
          state_d = StWaitAckLow;
          cnt_clr = 1'b1;
          box_d   = box_q + 1'b1;
        end else if (timer_q == TimerW'(EJECT_TIMEOUT - 1)) begin
          state_d = StFault;
        end
      end
      StWaitAckLow: begin
        if (!eject_ack) state_d = StWaitBox;
      end
      StFault: begin
        if (fault_clr) state_d = StEject;
      end
      default: state_d = StWaitBox;
    endcase
    timer_d = (state_q == StEject && state_d == StEject) ? timer_q + 1'b1 : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StWaitBox;
      item_q  <= 1'b0;
      timer_q <= '0;
      box_q   <= '0;
      conv_q  <= 1'b0;
      req_q   <= 1'b0;
      lost_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      item_q  <= item_sensor;
      timer_q <= timer_d;
      box_q   <= box_d;
      conv_q  <= (state_d == StFill);
      req_q   <= (state_d == StEject);
      lost_q  <= item_evt && (state_q != StFill);
      fault_q <= (state_d == StFault);
    end
  end

  egg_box_controller_mod_n_counter #(
    .N (ITEMS_PER_BOX),
    .W (CNT_W)
  ) u_item_cnt (
    .clk_i   (clock),
    .rst_i   (reset),
    .en_i    (cnt_en),
    .clr_i   (cnt_clr),
    .count_o (item_count),
    .last_o  (cnt_last)
  );

  assign conveyor_en = conv_q;
  assign eject_req   = req_q;
  assign box_count   = box_q;
  assign lost_item   = lost_q;
  assign fault       = fault_q;

endmodule
